exec_sequencer: RTL and testbench

//  Execute-stage controller for the V850 integer datapath. Accepts one decoded format-I/II

---
 rtl/exec_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_exec_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : exec_sequencer
//  Description : V850 execute-stage controller. Reads GR operands, launches
//                the ALU, then sequences GR writeback and PSW flag update.
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_sequencer #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [2:0]  op_i,
  input  logic [4:0]  reg1_idx_i,
  input  logic [4:0]  reg2_idx_i,
  input  logic [4:0]  imm5_i,
  output logic [4:0]  rf_raddr1_o,
  output logic [4:0]  rf_raddr2_o,
  input  logic [31:0] rf_rdata1_i,
  input  logic [31:0] rf_rdata2_i,
  output logic        alu_start_o,
  output logic        alu_sub_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  input  logic        alu_done_i,
  input  logic [31:0] alu_result_i,
  input  logic [3:0]  alu_flags_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        psw_we_o,
  output logic [3:0]  psw_flags_o,
  output logic        illegal_o,
  output logic        timeout_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WB    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [4:0]       reg1_q, reg1_d;
  logic [4:0]       reg2_q, reg2_d;
  logic [4:0]       imm_q, imm_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             illegal_q, illegal_d;

  logic             w_is_alu;
  logic             w_is_imm;
  logic             w_is_sub;
  logic             w_writes_gr;
  logic [31:0]      w_operand_b;

  assign w_is_alu    = (op_q <= 3'd3);
  assign w_is_imm    = (op_q == 3'd1) || (op_q == 3'd5);
  assign w_is_sub    = (op_q == 3'd2) || (op_q == 3'd3);
  assign w_writes_gr = (op_q != 3'd3);
  assign w_operand_b = w_is_imm ? {{27{imm_q[4]}}, imm_q} : rf_rdata1_i;

  assign illegal_o = illegal_q;
  assign timeout_o = timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      reg1_q    <= 5'd0;
      reg2_q    <= 5'd0;
      imm_q     <= 5'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      result_q  <= 32'd0;
      flags_q   <= 4'd0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      reg1_q    <= reg1_d;
      reg2_q    <= reg2_d;
      imm_q     <= imm_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    reg1_d        = reg1_q;
    reg2_d        = reg2_q;
    imm_d         = imm_q;
    a_d           = a_q;
    b_d           = b_q;
    result_d      = result_q;
    flags_d       = flags_q;
    cnt_d         = cnt_q;
    timeout_d     = timeout_q;
    illegal_d     = 1'b0;
    instr_ready_o = 1'b0;
    rf_raddr1_o   = 5'd0;
    rf_raddr2_o   = 5'd0;
    alu_start_o   = 1'b0;
    alu_sub_o     = 1'b0;
    alu_a_o       = 32'd0;
    alu_b_o       = 32'd0;
    rf_we_o       = 1'b0;
    rf_waddr_o    = 5'd0;
    rf_wdata_o    = 32'd0;
    psw_we_o      = 1'b0;
    psw_flags_o   = 4'd0;

    case (state_q)
      S_IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          op_d   = op_i;
          reg1_d = reg1_idx_i;
          reg2_d = reg2_idx_i;
          imm_d  = imm5_i;
          if (op_i[2:1] == 2'b11) begin
            illegal_d = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        rf_raddr1_o = reg1_q;
        rf_raddr2_o = reg2_q;
        state_d     = S_ISSUE;
      end

      S_ISSUE: begin
        // Read data arrives this cycle, so operands pass straight through to the ALU.
        rf_raddr1_o = reg1_q;
        rf_raddr2_o = reg2_q;
        a_d         = rf_rdata2_i;
        b_d         = w_operand_b;
        alu_a_o     = rf_rdata2_i;
        alu_b_o     = w_operand_b;
        if (w_is_alu) begin
          alu_start_o = 1'b1;
          alu_sub_o   = w_is_sub;
          cnt_d       = '0;
          state_d     = S_WAIT;
        end else begin
          result_d = w_operand_b;
          state_d  = S_WB;
        end
      end

      S_WAIT: begin
        alu_a_o   = a_q;
        alu_b_o   = b_q;
        alu_sub_o = w_is_sub;
        if (alu_done_i) begin
          result_d = alu_result_i;
          flags_d  = alu_flags_i;
          state_d  = S_WB;
        end else if (cnt_q == C_CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WB: begin
        rf_we_o     = w_writes_gr && (reg2_q != 5'd0);
        rf_waddr_o  = reg2_q;
        rf_wdata_o  = result_q;
        psw_we_o    = w_is_alu;
        psw_flags_o = flags_q;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An operation abandoned by reset must not leave side effects behind.
    if (reset) begin
      rf_we_o     = 1'b0;
      psw_we_o    = 1'b0;
      alu_start_o = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_sequencer
//  Description : Self-checking bench for exec_sequencer with GR file and ALU
//                models and a writeback scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_sequencer;

  localparam int MAX_WAIT = 16;

  logic        clk;
  logic        reset;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [2:0]  op_i;
  logic [4:0]  reg1_idx_i;
  logic [4:0]  reg2_idx_i;
  logic [4:0]  imm5_i;
  logic [4:0]  rf_raddr1_o;
  logic [4:0]  rf_raddr2_o;
  logic [31:0] rf_rdata1_i;
  logic [31:0] rf_rdata2_i;
  logic        alu_start_o;
  logic        alu_sub_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic        alu_done_i;
  logic [31:0] alu_result_i;
  logic [3:0]  alu_flags_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        psw_we_o;
  logic [3:0]  psw_flags_o;
  logic        illegal_o;
  logic        timeout_o;

  exec_sequencer #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .op_i          (op_i),
    .reg1_idx_i    (reg1_idx_i),
    .reg2_idx_i    (reg2_idx_i),
    .imm5_i        (imm5_i),
    .rf_raddr1_o   (rf_raddr1_o),
    .rf_raddr2_o   (rf_raddr2_o),
    .rf_rdata1_i   (rf_rdata1_i),
    .rf_rdata2_i   (rf_rdata2_i),
    .alu_start_o   (alu_start_o),
    .alu_sub_o     (alu_sub_o),
    .alu_a_o       (alu_a_o),
    .alu_b_o       (alu_b_o),
    .alu_done_i    (alu_done_i),
    .alu_result_i  (alu_result_i),
    .alu_flags_i   (alu_flags_i),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .psw_we_o      (psw_we_o),
    .psw_flags_o   (psw_flags_o),
    .illegal_o     (illegal_o),
    .timeout_o     (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- GR file model ----------------
  logic [31:0] rf_model [32];
  logic        pl_we;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_we) rf_model[pl_addr] <= pl_data;
    else if (rf_we_o) rf_model[rf_waddr_o] <= rf_wdata_o;
    rf_rdata1_i <= (rf_raddr1_o == 5'd0) ? 32'd0 : rf_model[rf_raddr1_o];
    rf_rdata2_i <= (rf_raddr2_o == 5'd0) ? 32'd0 : rf_model[rf_raddr2_o];
  end

  // ---------------- ALU model (alu_delay 0 = never completes) ----------------
  int          alu_delay;
  int          alu_cnt;
  int          start_cnt;
  logic        model_done;
  logic        manual_done;
  logic [32:0] alu_wide;
  logic        alu_ov;

  assign alu_done_i = model_done | manual_done;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (reset) begin
      alu_cnt <= 0;
    end else if (alu_start_o) begin
      start_cnt <= start_cnt + 1;
      if (alu_sub_o) begin
        alu_wide = {1'b0, alu_a_o} - {1'b0, alu_b_o};
        alu_ov   = (alu_a_o[31] != alu_b_o[31]) && (alu_wide[31] != alu_a_o[31]);
      end else begin
        alu_wide = {1'b0, alu_a_o} + {1'b0, alu_b_o};
        alu_ov   = (alu_a_o[31] == alu_b_o[31]) && (alu_wide[31] != alu_a_o[31]);
      end
      alu_result_i <= alu_wide[31:0];
      alu_flags_i  <= {alu_wide[32], alu_ov, alu_wide[31], alu_wide[31:0] == 32'd0};
      if (alu_delay == 1) model_done <= 1'b1;
      else if (alu_delay > 1) alu_cnt <= alu_delay - 1;
    end else if (alu_cnt > 0) begin
      alu_cnt <= alu_cnt - 1;
      if (alu_cnt == 1) model_done <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        psw_we;
    logic [3:0]  flags;
  } wb_t;

  wb_t exp_q[$];
  int  checks;
  int  errors;

  task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic push_wb(input logic we, input logic [4:0] a, input logic [31:0] d,
                         input logic pwe, input logic [3:0] f);
    wb_t e;
    e.rf_we = we; e.waddr = a; e.wdata = d; e.psw_we = pwe; e.flags = f;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge of cycle 1 (accept happened at the posedge ending cycle 0).
  task automatic issue(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] imm);
    int n;
    n = 0;
    while (!instr_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    instr_valid_i = 1'b1; op_i = op; reg1_idx_i = r1; reg2_idx_i = r2; imm5_i = imm;
    @(negedge clk);
    instr_valid_i = 1'b0;
  endtask

  task automatic wait_ready(input int start, output int lat);
    lat = start;
    while (!instr_ready_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    logic [120:0] outs;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (instr_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", instr_ready_o);
    end
    outs = {rf_raddr1_o, rf_raddr2_o, alu_start_o, alu_sub_o, alu_a_o, alu_b_o, rf_we_o,
            rf_waddr_o, rf_wdata_o, psw_we_o, psw_flags_o, illegal_o, timeout_o};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", outs);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_reg();
    int lat;
    set_reg(5'd3, 32'd7);
    set_reg(5'd5, 32'hFFFF_FFFF);
    alu_delay = 1;
    push_wb(1'b1, 5'd5, 32'd6, 1'b1, 4'b1000);
    issue(3'd0, 5'd3, 5'd5, 5'd0);
    checks++;
    if ({rf_raddr1_o, rf_raddr2_o, instr_ready_o} !== {5'd3, 5'd5, 1'b0}) begin
      errors++; $display("FAIL add_read got %h/%h rdy %b want 3/5 rdy 0",
                         rf_raddr1_o, rf_raddr2_o, instr_ready_o);
    end
    @(negedge clk);
    checks++;
    if ({alu_start_o, alu_sub_o, alu_a_o, alu_b_o} !== {1'b1, 1'b0, 32'hFFFF_FFFF, 32'd7}) begin
      errors++; $display("FAIL add_issue got st %b sub %b a %h b %h want 1 0 ffffffff 00000007",
                         alu_start_o, alu_sub_o, alu_a_o, alu_b_o);
    end
    wait_ready(2, lat);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL add_latency got %0d want 5", lat); end
    @(negedge clk);
    checks++;
    if (rf_model[5] !== 32'd6) begin
      errors++; $display("FAIL add_r5 got %h want 00000006", rf_model[5]);
    end
  endtask

  task automatic test_add_imm();
    int lat;
    set_reg(5'd2, 32'd1);
    alu_delay = 2;
    push_wb(1'b1, 5'd2, 32'hFFFF_FFFF, 1'b1, 4'b0010);
    issue(3'd1, 5'd9, 5'd2, 5'b11110);
    @(negedge clk);
    checks++;
    if ({alu_start_o, alu_a_o, alu_b_o} !== {1'b1, 32'd1, 32'hFFFF_FFFE}) begin
      errors++; $display("FAIL addi_issue got st %b a %h b %h want 1 00000001 fffffffe",
                         alu_start_o, alu_a_o, alu_b_o);
    end
    @(negedge clk);
    checks++;
    if ({alu_start_o, alu_a_o, alu_b_o} !== {1'b0, 32'd1, 32'hFFFF_FFFE}) begin
      errors++; $display("FAIL addi_hold got st %b a %h b %h want 0 00000001 fffffffe",
                         alu_start_o, alu_a_o, alu_b_o);
    end
    wait_ready(3, lat);
    checks++;
    if (lat != 6) begin errors++; $display("FAIL addi_latency got %0d want 6", lat); end
  endtask

  task automatic test_cmp_mov();
    int lat;
    int starts;
    set_reg(5'd1, 32'h1234);
    set_reg(5'd2, 32'h1234);
    alu_delay = 1;
    push_wb(1'b0, 5'd0, 32'd0, 1'b1, 4'b0001);
    issue(3'd3, 5'd1, 5'd2, 5'd0);
    @(negedge clk);
    checks++;
    if ({alu_start_o, alu_sub_o} !== 2'b11) begin
      errors++; $display("FAIL cmp_issue got st %b sub %b want 1 1", alu_start_o, alu_sub_o);
    end
    wait_ready(2, lat);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL cmp_latency got %0d want 5", lat); end
    checks++;
    if (rf_model[2] !== 32'h1234) begin
      errors++; $display("FAIL cmp_r2 got %h want 00001234", rf_model[2]);
    end
    starts = start_cnt;
    issue(3'd5, 5'd0, 5'd0, 5'd3);
    wait_ready(1, lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL movi_latency got %0d want 4", lat); end
    checks++;
    if (start_cnt != starts) begin
      errors++; $display("FAIL movi_start got %0d starts want %0d", start_cnt, starts);
    end
    push_wb(1'b1, 5'd7, 32'd7, 1'b0, 4'd0);
    issue(3'd4, 5'd3, 5'd7, 5'd0);
    wait_ready(1, lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL movr_latency got %0d want 4", lat); end
    @(negedge clk);
    checks++;
    if (rf_model[7] !== 32'd7 || start_cnt != starts) begin
      errors++; $display("FAIL movr_r7 got %h starts %0d want 00000007 starts %0d",
                         rf_model[7], start_cnt, starts);
    end
  endtask

  task automatic test_timeout();
    int lat;
    alu_delay = 0;
    checks++;
    if (timeout_o !== 1'b0) begin errors++; $display("FAIL timeout_pre got %b want 0", timeout_o); end
    issue(3'd0, 5'd3, 5'd5, 5'd0);
    wait_ready(1, lat);
    checks++;
    if (lat != MAX_WAIT + 3) begin
      errors++; $display("FAIL timeout_latency got %0d want %0d", lat, MAX_WAIT + 3);
    end
    checks++;
    if (timeout_o !== 1'b1) begin errors++; $display("FAIL timeout_set got %b want 1", timeout_o); end
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({timeout_o, instr_ready_o} !== 2'b11 || rf_model[5] !== 32'd6) begin
      errors++; $display("FAIL timeout_late got to %b rdy %b r5 %h want 1 1 00000006",
                         timeout_o, instr_ready_o, rf_model[5]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (timeout_o !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", timeout_o); end
  endtask

  task automatic test_illegal();
    issue(3'd6, 5'd3, 5'd5, 5'd1);
    checks++;
    if ({illegal_o, instr_ready_o, rf_raddr1_o, rf_raddr2_o, alu_start_o} !== {2'b11, 11'd0}) begin
      errors++; $display("FAIL illegal_pulse got ill %b rdy %b ra %h/%h st %b want 1 1 0/0 0",
                         illegal_o, instr_ready_o, rf_raddr1_o, rf_raddr2_o, alu_start_o);
    end
    @(negedge clk);
    checks++;
    if ({illegal_o, instr_ready_o, rf_raddr1_o} !== {2'b01, 5'd0}) begin
      errors++; $display("FAIL illegal_single got ill %b rdy %b ra %h want 0 1 0",
                         illegal_o, instr_ready_o, rf_raddr1_o);
    end
    issue(3'd7, 5'd1, 5'd2, 5'd0);
    checks++;
    if ({illegal_o, instr_ready_o} !== 2'b11) begin
      errors++; $display("FAIL illegal_op7 got ill %b rdy %b want 1 1", illegal_o, instr_ready_o);
    end
  endtask

  task automatic test_back_to_back_reset();
    int lat;
    alu_delay = 0;
    issue(3'd0, 5'd3, 5'd5, 5'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    manual_done = 1'b1;
    instr_valid_i = 1'b1; op_i = 3'd0; reg1_idx_i = 5'd3; reg2_idx_i = 5'd5; imm5_i = 5'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    manual_done = 1'b0;
    alu_delay = 1;
    push_wb(1'b1, 5'd5, 32'd13, 1'b1, 4'b0000);
    checks++;
    if (instr_ready_o !== 1'b1) begin
      errors++; $display("FAIL rst_ready got %b want 1", instr_ready_o);
    end
    @(negedge clk);
    instr_valid_i = 1'b0;
    checks++;
    if ({rf_raddr1_o, instr_ready_o} !== {5'd3, 1'b0}) begin
      errors++; $display("FAIL rst_accept got ra %h rdy %b want 3 0", rf_raddr1_o, instr_ready_o);
    end
    wait_ready(1, lat);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL rst_latency got %0d want 5", lat); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; instr_valid_i = 1'b0; op_i = 3'd0; reg1_idx_i = 5'd0; reg2_idx_i = 5'd0;
    imm5_i = 5'd0; pl_we = 1'b0; pl_addr = 5'd0; pl_data = 32'd0; manual_done = 1'b0;
    alu_delay = 1; alu_cnt = 0; start_cnt = 0;
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;

    fork
      forever begin
        wb_t e;
        @(negedge clk);
        if (rf_we_o || psw_we_o) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL wb_unexpected got we %b addr %h data %h psw %b flags %b",
                               rf_we_o, rf_waddr_o, rf_wdata_o, psw_we_o, psw_flags_o);
          end else begin
            e = exp_q.pop_front();
            if (rf_we_o !== e.rf_we || psw_we_o !== e.psw_we ||
                (e.rf_we && (rf_waddr_o !== e.waddr || rf_wdata_o !== e.wdata)) ||
                (e.psw_we && psw_flags_o !== e.flags)) begin
              errors++;
              $display("FAIL wb_compare got we %b %h %h psw %b %b want we %b %h %h psw %b %b",
                       rf_we_o, rf_waddr_o, rf_wdata_o, psw_we_o, psw_flags_o,
                       e.rf_we, e.waddr, e.wdata, e.psw_we, e.flags);
            end
          end
        end
      end
    join_none

    test_reset();
    test_add_reg();
    test_add_imm();
    test_cmp_mov();
    test_timeout();
    test_illegal();
    test_back_to_back_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL wb_missing got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
